// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types for the 5-stage core hazard controller.
// Rev    : 1.0
// ============================================================================
package pipe_pkg;

    localparam int REG_AW_DEF = 4;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : ID-stage hazard inputs and pipeline control outputs.
// Rev    : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src_a;
    logic [REG_AW-1:0] id_src_b;
    logic              id_use_a;
    logic              id_use_b;
    logic [REG_AW-1:0] id_dest;
    logic              id_wreg;
    logic              id_rmem;
    logic              id_multi;
    logic              ex_jump;

    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              idex_flush;
    logic              exmem_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_src_a, id_src_b, id_use_a, id_use_b, id_dest,
               id_wreg, id_rmem, id_multi, ex_jump,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_src_a, id_src_b, id_use_a, id_use_b, id_dest,
               id_wreg, id_rmem, id_multi, ex_jump,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Event counter that sticks at all-ones.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Stall/flush/forward control for the IF-ID-EX-MEM-WB pipeline.
// Rev    : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int                  c_mcnt_w    = $clog2(MULTI_LAT);
    localparam logic [c_mcnt_w-1:0] c_mcnt_load = c_mcnt_w'(MULTI_LAT - 1);
    localparam logic [c_mcnt_w-1:0] c_mcnt_one  = c_mcnt_w'(1);

    hz_state_e           r_state;
    logic [c_mcnt_w-1:0] r_mcnt;

    logic              r_ex_v, r_ex_wreg, r_ex_rmem, r_ex_use_a, r_ex_use_b;
    logic [REG_AW-1:0] r_ex_dest, r_ex_src_a, r_ex_src_b;
    logic              r_mem_v, r_mem_wreg;
    logic [REG_AW-1:0] r_mem_dest;
    logic              r_wb_v, r_wb_wreg;
    logic [REG_AW-1:0] r_wb_dest;

    logic     w_hold, w_jump, w_load_use, w_multi_start;
    logic     w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_bubble;
    fwd_sel_e w_fwd_a, w_fwd_b;
    logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

    assign w_hold = (r_state == ST_MULTI);
    // A jump arriving while a multicycle op holds the pipe is not legal and is dropped.
    assign w_jump = bus.ex_jump & ~w_hold;
    assign w_load_use = bus.id_valid & r_ex_v & r_ex_rmem & (r_ex_dest != '0) &
                        ((bus.id_use_a & (bus.id_src_a == r_ex_dest)) |
                         (bus.id_use_b & (bus.id_src_b == r_ex_dest)));

    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_en      = 1'b1;
        w_idex_flush   = 1'b0;
        w_exmem_bubble = 1'b0;
        if (!rst) begin
            if (w_hold) begin
                w_pc_en        = 1'b0;
                w_ifid_en      = 1'b0;
                w_idex_en      = 1'b0;
                w_exmem_bubble = 1'b1;
            end else if (w_jump) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
            end
        end
    end

    // MEM is checked first so the youngest producer of a register wins.
    always_comb begin
        w_fwd_a = FWD_REG;
        w_fwd_b = FWD_REG;
        if (!rst && r_ex_v) begin
            if (r_ex_use_a) begin
                if (r_mem_v && r_mem_wreg && (r_mem_dest != '0) && (r_mem_dest == r_ex_src_a))
                    w_fwd_a = FWD_MEM;
                else if (r_wb_v && r_wb_wreg && (r_wb_dest != '0) && (r_wb_dest == r_ex_src_a))
                    w_fwd_a = FWD_WB;
            end
            if (r_ex_use_b) begin
                if (r_mem_v && r_mem_wreg && (r_mem_dest != '0) && (r_mem_dest == r_ex_src_b))
                    w_fwd_b = FWD_MEM;
                else if (r_wb_v && r_wb_wreg && (r_wb_dest != '0) && (r_wb_dest == r_ex_src_b))
                    w_fwd_b = FWD_WB;
            end
        end
    end

    assign w_multi_start = w_idex_en & ~w_idex_flush & bus.id_valid & bus.id_multi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_mcnt     <= '0;
            r_ex_v     <= 1'b0;
            r_ex_wreg  <= 1'b0;
            r_ex_rmem  <= 1'b0;
            r_ex_use_a <= 1'b0;
            r_ex_use_b <= 1'b0;
            r_ex_dest  <= '0;
            r_ex_src_a <= '0;
            r_ex_src_b <= '0;
            r_mem_v    <= 1'b0;
            r_mem_wreg <= 1'b0;
            r_mem_dest <= '0;
            r_wb_v     <= 1'b0;
            r_wb_wreg  <= 1'b0;
            r_wb_dest  <= '0;
        end else begin
            if (r_state == ST_RUN) begin
                if (w_multi_start) begin
                    r_state <= ST_MULTI;
                    r_mcnt  <= c_mcnt_load;
                end
            end else begin
                if (r_mcnt == c_mcnt_one)
                    r_state <= ST_RUN;
                r_mcnt <= r_mcnt - c_mcnt_one;
            end

            if (w_idex_en) begin
                r_ex_v     <= bus.id_valid & ~w_idex_flush;
                r_ex_use_a <= bus.id_use_a & ~w_idex_flush;
                r_ex_use_b <= bus.id_use_b & ~w_idex_flush;
                r_ex_wreg  <= bus.id_wreg;
                r_ex_rmem  <= bus.id_rmem;
                r_ex_dest  <= bus.id_dest;
                r_ex_src_a <= bus.id_src_a;
                r_ex_src_b <= bus.id_src_b;
            end

            r_mem_v    <= r_ex_v & ~w_exmem_bubble;
            r_mem_wreg <= r_ex_wreg;
            r_mem_dest <= r_ex_dest;
            r_wb_v     <= r_mem_v;
            r_wb_wreg  <= r_mem_wreg;
            r_wb_dest  <= r_mem_dest;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~w_pc_en),
        .count (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_jump),
        .count (w_flush_cnt)
    );

    assign bus.pc_en        = w_pc_en;
    assign bus.ifid_en      = w_ifid_en;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_en      = w_idex_en;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.exmem_bubble = w_exmem_bubble;
    assign bus.fwd_a        = w_fwd_a;
    assign bus.fwd_b        = w_fwd_b;
    assign bus.stall_cnt    = w_stall_cnt;
    assign bus.flush_cnt    = w_flush_cnt;

endmodule
`default_nettype wire
